// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M/RV64M multiply/divide; define ALU_MULDIV_FAST_MUL_EN for a single-cycle multiplier
module alu_muldiv #(
  parameter int XLEN = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            kill,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy
);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
  logic [1:0]        state;
  logic [2:0]        op_r;
  logic              neg_r;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc, acc_nxt, prod;
  logic [CNT_W-1:0]  cnt;
  logic              a_sgn, b_sgn, sa, sb, neg, is_div, div0, ovf, mz, special;
  logic [XLEN-1:0]   a_mag, b_mag, spec_data, q, r, res;
  logic [XLEN:0]     msum, dtrial;
`ifdef ALU_MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fprod, fsig;
  logic [XLEN-1:0]   fres;
`endif
  assign req_ready  = state == IDLE;
  assign resp_valid = state == DONE;
  assign busy       = state != IDLE;
  // request decode: operand magnitudes, result sign and the shortcut cases
  always_comb begin
    a_sgn     = req_op == 3'd0 || req_op == 3'd1 || req_op == 3'd2 || req_op == 3'd4 || req_op == 3'd6;
    b_sgn     = req_op == 3'd0 || req_op == 3'd1 || req_op == 3'd4 || req_op == 3'd6;
    sa        = a_sgn && req_a[XLEN-1];
    sb        = b_sgn && req_b[XLEN-1];
    neg       = (req_op[2] && req_op[1]) ? sa : sa ^ sb;
    a_mag     = sa ? -req_a : req_a;
    b_mag     = sb ? -req_b : req_b;
    is_div    = req_op[2];
    div0      = is_div && req_b == {XLEN{1'b0}};
    ovf       = (req_op == 3'd4 || req_op == 3'd6) && req_a == {1'b1, {XLEN-1{1'b0}}} && req_b == {XLEN{1'b1}};
    mz        = !is_div && (req_a == {XLEN{1'b0}} || req_b == {XLEN{1'b0}});
    special   = div0 || ovf || mz;
    spec_data = div0 ? (req_op[1] ? req_a : {XLEN{1'b1}}) :
                ovf  ? (req_op[1] ? {XLEN{1'b0}} : req_a) : {XLEN{1'b0}};
  end
  // one shift-add or restoring-subtract step, and the signed result it would give
  always_comb begin
    msum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, acc[0] ? opnd : {XLEN{1'b0}}};
    dtrial  = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
    acc_nxt = !op_r[2] ? {msum, acc[XLEN-1:1]} :
              dtrial[XLEN] ? {acc[2*XLEN-2:0], 1'b0} : {dtrial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    prod    = neg_r ? -acc_nxt : acc_nxt;
    q       = neg_r ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    r       = neg_r ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
    res     = op_r[2] ? (op_r[1] ? r : q) : (op_r == 3'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  end
`ifdef ALU_MULDIV_FAST_MUL_EN
  // wide combinational product used when the fast multiplier is built in
  always_comb begin
    fprod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    fsig  = neg ? -fprod : fprod;
    fres  = req_op == 3'd0 ? fsig[XLEN-1:0] : fsig[2*XLEN-1:XLEN];
  end
`endif
  // control FSM with operand latching and result capture; kill overrides everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_r      <= '0;
      neg_r     <= 1'b0;
      opnd      <= '0;
      acc       <= '0;
      cnt       <= '0;
      resp_data <= '0;
    end else if (kill) begin
      state <= IDLE;
    end else if (state == IDLE && req_valid) begin
      op_r  <= req_op;
      neg_r <= neg;
      opnd  <= is_div ? b_mag : a_mag;
      acc   <= {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
      cnt   <= CNT_W'(XLEN - 1);
      if (special) begin
        resp_data <= spec_data;
        state     <= DONE;
`ifdef ALU_MULDIV_FAST_MUL_EN
      end else if (!is_div) begin
        resp_data <= fres;
        state     <= DONE;
`endif
      end else begin
        state <= CALC;
      end
    end else if (state == CALC) begin
      acc <= acc_nxt;
      cnt <= cnt - CNT_W'(1);
      if (cnt == '0) begin
        resp_data <= res;
        state     <= DONE;
      end
    end else if (state == DONE && resp_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed vectors for alu_muldiv at XLEN=32
module tb_alu_muldiv;
  logic        clk = 1'b0, rst_n = 1'b0, kill = 1'b0, req_valid = 1'b0, resp_ready = 1'b0;
  logic [2:0]  req_op = '0;
  logic [31:0] req_a = '0, req_b = '0, resp_data;
  logic        req_ready, resp_valid, busy;
  int          n_chk = 0, n_fail = 0, lat, seen;
`ifdef ALU_MULDIV_FAST_MUL_EN
  localparam int ML = 1;
`else
  localparam int ML = 33;
`endif
  alu_muldiv dut (
    .clk(clk), .rst_n(rst_n), .kill(kill), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    req_op = op;
    req_a = a;
    req_b = b;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask
  task automatic wait_resp(output int l);
    l = 1;
    while (!resp_valid && l < 200) begin
      @(negedge clk);
      l++;
    end
  endtask
  task automatic retire(input string tag);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, "_idle"}, {req_ready, resp_valid, busy}, 3'b100);
  endtask
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int l;
    issue(op, a, b);
    wait_resp(l);
    check({tag, "_lat"}, l, exp_lat);
    check({tag, "_data"}, resp_data, exp);
    retire(tag);
  endtask
  initial begin
    @(negedge clk);
    check("rst_outs", {req_ready, resp_valid, busy, resp_data}, {3'b100, 32'h0});
    rst_n = 1'b1;
    run_op("mul",     3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, ML);
    run_op("mulh",    3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, ML);
    run_op("mulhu",   3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, ML);
    run_op("mulhsu",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ML);
    run_op("mulhu_m", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, ML);
    run_op("mul_z",   3'd0, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 1);
    run_op("div",     3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33);
    run_op("rem",     3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33);
    run_op("divu",    3'd5, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu",    3'd7, 32'd100, 32'd7, 32'd2, 33);
    run_op("divu_0",  3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem_0",   3'd6, 32'd5, 32'd0, 32'd5, 1);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    issue(3'd5, 32'd100, 32'd7);
    wait_resp(lat);
    check("bp_lat", lat, 33);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold", {req_ready, resp_valid, resp_data}, {2'b01, 32'd14});
    end
    retire("bp");
    @(negedge clk);
    req_valid = 1'b1;
    kill = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    kill = 1'b0;
    check("kill_noacc", {busy, req_ready}, 2'b01);
    issue(3'd5, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_idle", {req_ready, resp_valid, busy, resp_data}, {3'b100, 32'd14});
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    check("kill_novalid", seen, 0);
    run_op("divu_93", 3'd5, 32'd9, 32'd3, 32'd3, 33);
    issue(3'd5, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid", {req_ready, resp_valid, busy, resp_data}, {3'b100, 32'h0});
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 3'd7, 32'd1000, 32'd3, 32'd1, 33);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
